// File: rtl/hall_call_panel_pkg.sv
// Shared constants and FSM encoding for the hall-call panel and elevator scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hall_call_panel_pkg;

    localparam int NUM_FLOORS = 16;
    localparam int FLOOR_W    = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } panel_state_t;

endpackage

// File: rtl/hall_call_panel_rr_pick16.sv
// Round-robin picker: first set request at or above ptr, wrapping 15 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to consume the pick.
module rr_pick16
    import hall_call_panel_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]    ptr,
    output logic [FLOOR_W-1:0]    idx,
    output logic                  found
);

    logic [NUM_FLOORS-1:0] rot;
    logic [FLOOR_W-1:0]    off;

    // Rotate requests so ptr sits at bit 0, then take the lowest set offset.
    always_comb begin
        rot   = '0;
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            rot[i] = req[FLOOR_W'(ptr + FLOOR_W'(i))];
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = FLOOR_W'(i);
                found = 1'b1;
            end
        end
    end

    assign idx = ptr + off;

endmodule

// File: rtl/hall_call_panel.sv
// Hall-call panel: latches button presses, lights lamps, issues floor requests round-robin.
// Latency: press sampled at E0 -> lamp after E0 -> req_valid pulse after E1 (FSM idle).
// Backpressure: none from downstream; requests are rate-limited by a GAP_CYC idle gap.
module hall_call_panel
    import hall_call_panel_pkg::*;
#(
    parameter int GAP_CYC     = 2,
    parameter int REISSUE_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    floor_l1,
    input  logic [FLOOR_W-1:0]    floor_l2,
    output logic                  req_valid,
    output logic [FLOOR_W-1:0]    req_new,
    output logic [NUM_FLOORS-1:0] lamp,
    output logic                  busy
);

    panel_state_t          state, state_nxt;
    logic [NUM_FLOORS-1:0] btn_q;
    logic                  primed;
    logic [NUM_FLOORS-1:0] pending, pending_nxt;
    logic [NUM_FLOORS-1:0] issued, issued_nxt;
    logic [NUM_FLOORS-1:0] clr, btn_rise, cand;
    logic [FLOOR_W-1:0]    rr_ptr;
    logic [FLOOR_W-1:0]    pick_idx;
    logic                  pick_found;
    logic                  issue_go;
    logic [7:0]            gap_cnt;
    logic [15:0]           sweep_cnt;
    logic                  sweep_tc;

    // A floor is cleared whenever either car is standing at it.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clr[i] = (floor_l1 == FLOOR_W'(i)) || (floor_l2 == FLOOR_W'(i));
        end
    end

    // No edges during the first cycle out of reset: that cycle only loads the
    // button history, so buttons held across reset must be released first.
    assign btn_rise    = primed ? (btn & ~btn_q) : '0;
    assign pending_nxt = (pending | btn_rise) & ~clr;
    assign cand        = pending & ~issued & ~clr;
    assign sweep_tc    = (sweep_cnt == 16'(REISSUE_CYC - 1));

    rr_pick16 u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Issued bookkeeping: sweep clears all, a same-cycle issue still sets its bit.
    always_comb begin
        issued_nxt = sweep_tc ? '0 : issued;
        if (issue_go) begin
            issued_nxt[pick_idx] = 1'b1;
        end
        issued_nxt = issued_nxt & ~clr;
    end

    // FSM next-state: issue one request from IDLE, then sit out the gap.
    always_comb begin
        state_nxt = state;
        issue_go  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    issue_go  = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: call tracking, pointer, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q     <= '0;
            primed    <= 1'b0;
            pending   <= '0;
            issued    <= '0;
            rr_ptr    <= '0;
            gap_cnt   <= '0;
            sweep_cnt <= '0;
            req_valid <= 1'b0;
            req_new   <= '0;
            busy      <= 1'b0;
        end else begin
            btn_q     <= btn;
            primed    <= 1'b1;
            pending   <= pending_nxt;
            issued    <= issued_nxt;
            sweep_cnt <= sweep_tc ? 16'd0 : sweep_cnt + 16'd1;
            req_valid <= issue_go;
            busy      <= |pending_nxt;
            if (issue_go) begin
                req_new <= pick_idx;
                rr_ptr  <= pick_idx + FLOOR_W'(1);
                gap_cnt <= 8'(GAP_CYC);
            end else if (state == ST_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    assign lamp = pending;

endmodule

// File: tb/tb_hall_call_panel.sv
// Directed self-checking bench for hall_call_panel (main instance plus a short-sweep instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_hall_call_panel;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] btn, sbtn;
    logic [3:0]  fl1, fl2, sfl1, sfl2;
    logic        req_valid, busy, sw_req_valid, sw_busy;
    logic [3:0]  req_new, sw_req_new;
    logic [15:0] lamp, sw_lamp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n0, c0, m0;

    logic [3:0] pf[$];
    int         pc[$];
    logic [3:0] sf[$];

    hall_call_panel #(.GAP_CYC(2), .REISSUE_CYC(1024)) dut (
        .clk(clk), .rst(rst), .btn(btn), .floor_l1(fl1), .floor_l2(fl2),
        .req_valid(req_valid), .req_new(req_new), .lamp(lamp), .busy(busy)
    );

    hall_call_panel #(.GAP_CYC(2), .REISSUE_CYC(16)) dut_sw (
        .clk(clk), .rst(rst), .btn(sbtn), .floor_l1(sfl1), .floor_l2(sfl2),
        .req_valid(sw_req_valid), .req_new(sw_req_new), .lamp(sw_lamp), .busy(sw_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every request pulse with the cycle it appeared in.
    always @(negedge clk) begin
        if (req_valid) begin
            pf.push_back(req_new);
            pc.push_back(cyc);
        end
        if (sw_req_valid) begin
            sf.push_back(sw_req_new);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; btn = '0; fl1 = '0; fl2 = '0; sbtn = '0; sfl1 = '0; sfl2 = '0;
        #3 rst = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_req_new", {28'd0, req_new}, 32'd0);
        chk("rst_lamp", {16'd0, lamp}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sw_lamp", {16'd0, sw_lamp}, 32'd0);
        tick; tick;
        rst = 1'b1;
        tick; tick;

        // Single press of floor 5.
        btn = 16'h0020;
        tick;
        btn = '0;
        chk("p5_lamp", {16'd0, lamp}, 32'h20);
        chk("p5_busy", {31'd0, busy}, 32'd1);
        chk("p5_noreq_yet", {31'd0, req_valid}, 32'd0);
        tick;
        chk("p5_req_valid", {31'd0, req_valid}, 32'd1);
        chk("p5_req_new", {28'd0, req_new}, 32'd5);
        tick;
        chk("p5_pulse_end", {31'd0, req_valid}, 32'd0);
        chk("p5_req_new_hold", {28'd0, req_new}, 32'd5);
        fl1 = 4'd5;
        tick;
        fl1 = 4'd0;
        chk("p5_clr_lamp", {16'd0, lamp}, 32'd0);
        chk("p5_clr_busy", {31'd0, busy}, 32'd0);
        tick; tick;

        // Bring rr_ptr to 10 by issuing and servicing floor 9.
        btn = 16'h0200;
        tick;
        btn = '0;
        tick;
        chk("pre9_req_new", {28'd0, req_new}, 32'd9);
        fl1 = 4'd9;
        tick;
        fl1 = 4'd0;
        tick; tick; tick;

        // Three simultaneous calls with rr_ptr=10: order 12, 3, 9, spacing 3.
        n0 = pf.size();
        btn = 16'h1208;
        tick;
        btn = '0;
        c0 = cyc;
        chk("rr_lamp", {16'd0, lamp}, 32'h1208);
        repeat (10) tick;
        chk("rr_count", pf.size() - n0, 32'd3);
        if (pf.size() >= n0 + 3) begin
            chk("rr_first", {28'd0, pf[n0]}, 32'd12);
            chk("rr_second", {28'd0, pf[n0+1]}, 32'd3);
            chk("rr_third", {28'd0, pf[n0+2]}, 32'd9);
            chk("rr_latency", pc[n0] - c0, 32'd1);
            chk("rr_space1", pc[n0+1] - pc[n0], 32'd3);
            chk("rr_space2", pc[n0+2] - pc[n0+1], 32'd3);
        end
        fl1 = 4'd3; fl2 = 4'd9;
        tick;
        fl1 = 4'd12; fl2 = 4'd0;
        tick;
        fl1 = 4'd0;
        chk("rr_clr_lamp", {16'd0, lamp}, 32'd0);
        tick; tick; tick;

        // Press at a floor where a car already stands.
        n0 = pf.size();
        fl1 = 4'd7;
        btn = 16'h0080;
        tick;
        btn = '0;
        tick; tick;
        chk("at7_lamp", {16'd0, lamp}, 32'd0);
        repeat (3) tick;
        chk("at7_noreq", pf.size() - n0, 32'd0);
        fl1 = 4'd0;
        tick;

        // Held button: one request only, and no re-arm until released.
        n0 = pf.size();
        btn = 16'h0004;
        repeat (50) tick;
        chk("hold_count", pf.size() - n0, 32'd1);
        chk("hold_lamp", {16'd0, lamp}, 32'h4);
        fl1 = 4'd2;
        tick;
        fl1 = 4'd0;
        chk("hold_clr_lamp", {16'd0, lamp}, 32'd0);
        chk("hold_clr_busy", {31'd0, busy}, 32'd0);
        repeat (5) tick;
        chk("hold_no_rearm", pf.size() - n0, 32'd1);
        chk("hold_lamp_off", {16'd0, lamp}, 32'd0);
        btn = '0;
        tick;
        btn = 16'h0004;
        tick;
        chk("repress_lamp", {16'd0, lamp}, 32'h4);
        btn = '0;
        repeat (4) tick;
        chk("repress_count", pf.size() - n0, 32'd2);
        chk("repress_floor", {28'd0, pf[pf.size()-1]}, 32'd2);
        fl1 = 4'd2;
        tick;
        fl1 = 4'd0;
        tick; tick; tick;

        // Reset in the middle of a pulse with floors 1 and 6 pending, buttons held.
        btn = 16'h0042;
        tick;
        chk("r35_lamp", {16'd0, lamp}, 32'h42);
        tick;
        chk("r35_pulse", {31'd0, req_valid}, 32'd1);
        rst = 1'b0;
        #2;
        chk("r35_async_valid", {31'd0, req_valid}, 32'd0);
        chk("r35_async_lamp", {16'd0, lamp}, 32'd0);
        chk("r35_async_busy", {31'd0, busy}, 32'd0);
        chk("r35_async_new", {28'd0, req_new}, 32'd0);
        tick;
        rst = 1'b1;
        n0 = pf.size();
        repeat (20) tick;
        chk("r35_noreq", pf.size() - n0, 32'd0);
        chk("r35_lamp_off", {16'd0, lamp}, 32'd0);
        chk("r35_busy_off", {31'd0, busy}, 32'd0);
        btn = '0;
        tick;

        // Short sweep period: unserviced floor 4 gets re-issued, then serviced.
        sbtn = 16'h0010;
        tick;
        sbtn = '0;
        chk("sw_lamp", {16'd0, sw_lamp}, 32'h10);
        repeat (40) tick;
        chk("sw_reissued", {31'd0, (sf.size() >= 2)}, 32'd1);
        if (sf.size() >= 2) begin
            chk("sw_first_floor", {28'd0, sf[0]}, 32'd4);
            chk("sw_last_floor", {28'd0, sf[sf.size()-1]}, 32'd4);
        end
        sfl2 = 4'd4;
        tick;
        m0 = sf.size();
        chk("sw_clr_lamp", {16'd0, sw_lamp}, 32'd0);
        chk("sw_clr_busy", {31'd0, sw_busy}, 32'd0);
        repeat (40) tick;
        chk("sw_no_more", sf.size() - m0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hall_call_panel.md
HALL_CALL_PANEL -- requirements
Module: hall_call_panel

Interface
REQ-001 SHALL have parameter GAP_CYC, default 2: idle cycles enforced after each issued request; legal range 1..255.
REQ-002 SHALL have parameter REISSUE_CYC, default 1024: re-issue sweep period in cycles; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port btn, input, 16: hall-call buttons, one per floor 0..15, synchronous levels.
REQ-006 SHALL have port floor_l1, input, 4: current floor of car 1.
REQ-007 SHALL have port floor_l2, input, 4: current floor of car 2.
REQ-008 SHALL have port req_valid, output, 1: one-cycle request strobe to the elevator system's request input.
REQ-009 SHALL have port req_new, output, 4: requested floor; valid when req_valid=1.
REQ-010 SHALL have port lamp, output, 16: pending-call lamps, registered.
REQ-011 SHALL have port busy, output, 1: OR of all lamp bits.

Function
REQ-012 SHALL register btn each cycle; a call for floor i is captured only on a rising edge (btn[i]=1, previous sample 0); a held button generates no further calls.
REQ-013 SHALL set pending[i] on a captured edge; lamp equals pending.
REQ-014 SHALL clear pending[i] and issued[i] in any cycle where floor_l1==i or floor_l2==i; clear wins over a same-cycle set.
REQ-015 SHALL implement FSM states IDLE and GAP.
REQ-016 In IDLE, if any floor has pending=1 and issued=0, SHALL select one by round-robin: search from rr_ptr upward, wrapping 15->0.
REQ-017 On selection at edge E: req_valid=1 and req_new=idx for exactly the cycle after E; issued[idx] set; rr_ptr <= (idx+1) mod 16; state -> GAP; gap counter loaded.
REQ-018 A floor being cleared by REQ-014 in the same cycle SHALL NOT be selected.
REQ-019 In GAP, req_valid SHALL be 0; after exactly GAP_CYC cycles in GAP, state -> IDLE.
REQ-020 Minimum spacing between req_valid pulses SHALL be GAP_CYC+1 cycles.
REQ-021 Latency: btn rising at edge E0 -> lamp[i]=1 after E0 -> req_valid after E1, provided FSM is in IDLE and no other candidate precedes i.
REQ-022 req_new SHALL hold its last issued value while req_valid=0.
REQ-023 A free-running sweep counter SHALL count 0..REISSUE_CYC-1 and wrap; at terminal count all issued bits clear, so unserviced calls are re-issued.
REQ-024 If a sweep and an issue coincide, the issued bit of the floor being issued SHALL end set.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 On rst=0, asynchronously: req_valid=0, req_new=0, lamp=0, busy=0, pending=0, issued=0, btn history=0, rr_ptr=0, gap counter=0, sweep counter=0, state=IDLE.
REQ-027 Reset asserted mid-GAP or mid-pulse SHALL drop req_valid immediately and discard all calls; after release, buttons still held SHALL NOT register until released and pressed again.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, floor count (16) and floor index width (4); the elevator scheduler uses the same constants.
REQ-029 Round-robin selection SHALL be a sub-module rr_pick16 (16-bit request vector, 4-bit pointer in; 4-bit index and found flag out; purely combinational).

Verification
REQ-030 Reset; cars at 0 and 0; pulse btn[5] one cycle at E0 -> lamp[5]=1 after E0, req_valid=1 with req_new=5 one cycle after E1, then 0.
REQ-031 Press btn[3], btn[9], btn[12] on the same cycle with rr_ptr=10 -> issue order 12, 3, 9; pulses spaced exactly 3 cycles apart (GAP_CYC=2).
REQ-032 Press btn[7] while floor_l1=7 -> lamp[7] stays 0, no req_valid.
REQ-033 btn[4] issued, cars never reach 4, REISSUE_CYC=16 -> req_new=4 re-issued after the sweep wrap; floor_l2=4 clears lamp[4] and busy, with no further issues.
REQ-034 Hold btn[2] high through 50 cycles -> exactly one req_valid for floor 2; after floor_l1=2 clears it, no new call until btn[2] falls and rises again.
REQ-035 Assert rst during GAP with lamps 1 and 6 pending -> req_valid, lamp, busy go 0 immediately without a clock; after release, no requests are issued.
